// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding/packing pipeline for unrounded FP result records (FP_FORMAT 0=FP32, 1=FP64, 2=FP16).
// Optional inexact-result counter enabled by defining FP_RND_INEXACT_CNT_EN.
module fp_rnd_pipe #(
    parameter int FP_FORMAT = 0,
    localparam int EXP_WIDTH  = (FP_FORMAT == 1) ? 11 : (FP_FORMAT == 2) ? 5 : 8,
    localparam int MANT_WIDTH = (FP_FORMAT == 1) ? 52 : (FP_FORMAT == 2) ? 10 : 23,
    localparam int FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH,
    localparam int URND_WIDTH = FP_WIDTH + 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [URND_WIDTH-1:0] urnd_i,
    input  logic [2:0]            rm_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [FP_WIDTH-1:0]   result_o,
    output logic [4:0]            fflags_o
`ifdef FP_RND_INEXACT_CNT_EN
    ,
    output logic [15:0]           nx_cnt_o,
    input  logic                  nx_cnt_clr_i
`endif
);

    // urnd_i layout: {sign, exp, mant, rs[1:0], round_en, invalid, exp_cout[1:0]}
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES    = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0] EXP_MAX_FIN = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q;
    logic [EXP_WIDTH-1:0]  s1_exp_q;
    logic [MANT_WIDTH-1:0] s1_mant_q;
    logic [1:0]            s1_rs_q;
    logic                  s1_rnd_en_q;
    logic                  s1_inv_q;
    logic [1:0]            s1_ecout_q;
    logic [2:0]            s1_rm_q;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q;
    logic [EXP_WIDTH-1:0]  s2_exp_q;
    logic [MANT_WIDTH-1:0] s2_mant_q, s2_mant_d;
    logic                  s2_carry_q, s2_carry_d;
    logic                  s2_nx_q, s2_nx_d;
    logic                  s2_inv_q;
    logic [1:0]            s2_ecout_q;
    logic [2:0]            s2_rm_q;

    logic s2_ready;
    logic s1_load;
    logic s2_load;
    logic inc;

    assign s2_ready   = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s2_ready;
    assign s1_load    = in_valid_i && in_ready_o;
    assign s2_load    = s1_valid_q && s2_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_rs_q     <= '0;
            s1_rnd_en_q <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_ecout_q  <= '0;
            s1_rm_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_sign_q   <= urnd_i[URND_WIDTH-1];
                s1_exp_q    <= urnd_i[URND_WIDTH-2 -: EXP_WIDTH];
                s1_mant_q   <= urnd_i[6 +: MANT_WIDTH];
                s1_rs_q     <= urnd_i[5:4];
                s1_rnd_en_q <= urnd_i[3];
                s1_inv_q    <= urnd_i[2];
                s1_ecout_q  <= urnd_i[1:0];
                s1_rm_q     <= rm_i;
            end
        end
    end

    // Round-bit increment; reserved rounding-mode encodings behave as RNE.
    always_comb begin
        case (s1_rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign_q & (s1_rs_q[1] | s1_rs_q[0]);
            RM_RUP:  inc = !s1_sign_q & (s1_rs_q[1] | s1_rs_q[0]);
            RM_RMM:  inc = s1_rs_q[1];
            default: inc = s1_rs_q[1] & (s1_rs_q[0] | s1_mant_q[0]);
        endcase
        if (!s1_rnd_en_q) begin
            inc = 1'b0;
        end
        s2_nx_d = s1_rnd_en_q & (s1_rs_q[1] | s1_rs_q[0]);
        {s2_carry_d, s2_mant_d} = {1'b0, s1_mant_q} + {{MANT_WIDTH{1'b0}}, inc};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
            s2_carry_q <= 1'b0;
            s2_nx_q    <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_ecout_q <= '0;
            s2_rm_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                s2_sign_q  <= s1_sign_q;
                s2_exp_q   <= s1_exp_q;
                s2_mant_q  <= s2_mant_d;
                s2_carry_q <= s2_carry_d;
                s2_nx_q    <= s2_nx_d;
                s2_inv_q   <= s1_inv_q;
                s2_ecout_q <= s1_ecout_q;
                s2_rm_q    <= s1_rm_q;
            end
        end
    end

    logic [EXP_WIDTH-1:0]  exp_r;
    logic [MANT_WIDTH-1:0] mant_r;
    logic                  ovf;
    logic                  to_inf;

    // Packing runs off the stage-2 registers, so outputs hold while stalled.
    always_comb begin
        exp_r  = s2_carry_q ? (s2_exp_q + {{(EXP_WIDTH-1){1'b0}}, 1'b1}) : s2_exp_q;
        mant_r = s2_carry_q ? '0 : s2_mant_q;
        ovf    = (s2_ecout_q == 2'b01) || (s2_carry_q && (s2_exp_q == EXP_MAX_FIN));
        case (s2_rm_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s2_sign_q;
            RM_RUP:  to_inf = !s2_sign_q;
            default: to_inf = 1'b1;
        endcase

        result_o = {s2_sign_q, exp_r, mant_r};
        fflags_o = {3'b000, (s2_ecout_q == 2'b10) & s2_nx_q, s2_nx_q};
        if (s2_inv_q) begin
            result_o = {1'b0, EXP_ONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};
            fflags_o = 5'b10000;
        end else if (ovf) begin
            if (to_inf) begin
                result_o = {s2_sign_q, EXP_ONES, {MANT_WIDTH{1'b0}}};
            end else begin
                result_o = {s2_sign_q, EXP_MAX_FIN, {MANT_WIDTH{1'b1}}};
            end
            fflags_o = 5'b00101;
        end
    end

    assign out_valid_o = s2_valid_q;

`ifdef FP_RND_INEXACT_CNT_EN
    logic [15:0] nx_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nx_cnt_q <= '0;
        end else if (nx_cnt_clr_i) begin
            nx_cnt_q <= '0;
        end else if (out_valid_o && out_ready_i && fflags_o[0] && (nx_cnt_q != 16'hFFFF)) begin
            nx_cnt_q <= nx_cnt_q + 16'd1;
        end
    end

    assign nx_cnt_o = nx_cnt_q;
`endif

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Self-checking bench for fp_rnd_pipe (FP32): directed vectors, backpressure/reset sequences, random scoreboard.
module tb_fp_rnd_pipe;

    typedef struct {
        logic        sign;
        logic [7:0]  e;
        logic [22:0] m;
        logic [1:0]  rs;
        logic        ren;
        logic        inv;
        logic [1:0]  ec;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [37:0] urnd = '0;
    logic [2:0]  rm = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] result;
    logic [4:0]  fflags;
`ifdef FP_RND_INEXACT_CNT_EN
    logic [15:0] nxCnt;
    logic        nxCntClr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[16];

    fp_rnd_pipe #(.FP_FORMAT(0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .urnd_i      (urnd),
        .rm_i        (rm),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .result_o    (result),
        .fflags_o    (fflags)
`ifdef FP_RND_INEXACT_CNT_EN
        ,
        .nx_cnt_o    (nxCnt),
        .nx_cnt_clr_i(nxCntClr)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] mkRec(input vec_t v);
        return {v.sign, v.e, v.m, v.rs, v.ren, v.inv, v.ec};
    endfunction

    // Reference: round with integer arithmetic, then classify the rounded value.
    function automatic logic [36:0] refModel(input logic [37:0] rec, input logic [2:0] rmIn);
        logic        sign;
        int          e, m, mode, up, total, ee;
        logic        r, s, ren, inexact, toInf;
        logic [1:0]  ec;
        logic [31:0] res;
        logic [4:0]  fl;
        sign = rec[37];
        e    = int'(rec[36:29]);
        m    = int'(rec[28:6]);
        r    = rec[5];
        s    = rec[4];
        ren  = rec[3];
        ec   = rec[1:0];
        mode = (rmIn > 3'd4) ? 0 : int'(rmIn);
        if (rec[2]) return {32'h7FC00000, 5'b10000};
        inexact = ren && (r || s);
        up = 0;
        if (ren) begin
            case (mode)
                0: up = (r && (s || (m % 2 == 1))) ? 1 : 0;
                2: up = (sign && (r || s)) ? 1 : 0;
                3: up = (!sign && (r || s)) ? 1 : 0;
                4: up = r ? 1 : 0;
                default: up = 0;
            endcase
        end
        total = m + up;
        ee = e;
        if (total >= (1 << 23)) begin
            total = total - (1 << 23);
            ee = e + 1;
        end
        if (ec == 2'b01 || (ee == 255 && e != 255)) begin
            toInf = (mode == 1) ? 1'b0 : (mode == 2) ? sign : (mode == 3) ? !sign : 1'b1;
            res = toInf ? {sign, 8'hFF, 23'h0} : {sign, 8'hFE, 23'h7FFFFF};
            fl = 5'b00101;
        end else begin
            res = {sign, 8'(ee), 23'(total)};
            fl = {3'b000, (ec == 2'b10) && inexact, inexact};
        end
        return {res, fl};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Push one directed vector through an otherwise idle pipeline.
    task automatic applyStimulus(input int idx);
        int cnt;
        @(negedge clk);
        inValid  = 1'b1;
        urnd     = mkRec(vecs[idx]);
        rm       = vecs[idx].rm;
        outReady = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        cnt = 0;
        while (!outValid && cnt < 5) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput($sformatf("vec%0d_latency", idx), cnt, 1);
        checkOutput($sformatf("vec%0d_result", idx), result, vecs[idx].res);
        checkOutput($sformatf("vec%0d_fflags", idx), {27'b0, fflags}, {27'b0, vecs[idx].fl});
    endtask

    function automatic vec_t randVec();
        vec_t v;
        int pick;
        v.sign = 1'($urandom);
        v.e    = ($urandom_range(0, 3) == 0) ? 8'd254 : 8'($urandom_range(0, 254));
        v.m    = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        v.rs   = 2'($urandom);
        v.ren  = ($urandom_range(0, 7) != 0);
        v.inv  = ($urandom_range(0, 15) == 0);
        pick   = $urandom_range(0, 7);
        v.ec   = (pick == 0) ? 2'b01 : (pick == 1) ? 2'b10 : 2'b00;
        v.rm   = 3'($urandom_range(0, 7));
        v.res  = '0;
        v.fl   = '0;
        return v;
    endfunction

    logic [31:0] qRes[$];
    logic [4:0]  qFl[$];

    initial begin
        logic [36:0] expA, expB, expC, expV;
        vec_t rv;
        logic pending;
        int nxModel;
        int guard;

        vecs[0]  = '{1'b0, 8'd151, 23'h000000, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 32'h4B800000, 5'b00001};
        vecs[1]  = '{1'b0, 8'd151, 23'h000000, 2'b10, 1'b1, 1'b0, 2'b00, 3'b011, 32'h4B800001, 5'b00001};
        vecs[2]  = '{1'b0, 8'd151, 23'h000000, 2'b10, 1'b1, 1'b0, 2'b00, 3'b001, 32'h4B800000, 5'b00001};
        vecs[3]  = '{1'b0, 8'd150, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'b000, 32'h4B800000, 5'b00001};
        vecs[4]  = '{1'b0, 8'd254, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, 3'b000, 32'h7F800000, 5'b00101};
        vecs[5]  = '{1'b0, 8'd254, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, 3'b001, 32'h7F7FFFFF, 5'b00101};
        vecs[6]  = '{1'b1, 8'd254, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, 3'b011, 32'hFF7FFFFF, 5'b00101};
        vecs[7]  = '{1'b0, 8'd254, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'b000, 32'h7F800000, 5'b00101};
        vecs[8]  = '{1'b1, 8'd100, 23'h000123, 2'b11, 1'b1, 1'b1, 2'b01, 3'b010, 32'h7FC00000, 5'b10000};
        vecs[9]  = '{1'b0, 8'd0,   23'h000000, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 32'h00000000, 5'b00000};
        vecs[10] = '{1'b0, 8'd151, 23'h000000, 2'b10, 1'b1, 1'b0, 2'b00, 3'b100, 32'h4B800001, 5'b00001};
        vecs[11] = '{1'b1, 8'd151, 23'h000000, 2'b01, 1'b1, 1'b0, 2'b00, 3'b010, 32'hCB800001, 5'b00001};
        vecs[12] = '{1'b0, 8'd0,   23'h000005, 2'b01, 1'b1, 1'b0, 2'b10, 3'b001, 32'h00000005, 5'b00011};
        vecs[13] = '{1'b0, 8'd151, 23'h000001, 2'b10, 1'b1, 1'b0, 2'b00, 3'b111, 32'h4B800002, 5'b00001};
        vecs[14] = '{1'b0, 8'd151, 23'h000000, 2'b11, 1'b0, 1'b0, 2'b00, 3'b011, 32'h4B800000, 5'b00000};
        vecs[15] = '{1'b1, 8'd254, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, 3'b010, 32'hFF800000, 5'b00101};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_fflags", {27'b0, fflags}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, inReady}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(i);
        end

        // Backpressure: two accepted, third stalls, then drain in order.
        expA = refModel(mkRec(vecs[0]), vecs[0].rm);
        expB = refModel(mkRec(vecs[3]), vecs[3].rm);
        expC = refModel(mkRec(vecs[11]), vecs[11].rm);
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b1;
        urnd = mkRec(vecs[0]);
        rm = vecs[0].rm;
        #1;
        checkOutput("bp_ready_first", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        urnd = mkRec(vecs[3]);
        rm = vecs[3].rm;
        #1;
        checkOutput("bp_ready_second", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        urnd = mkRec(vecs[11]);
        rm = vecs[11].rm;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bp_ready_third", {31'b0, inReady}, 32'd0);
            checkOutput("bp_hold_valid", {31'b0, outValid}, 32'd1);
            checkOutput("bp_hold_result", result, expA[36:5]);
            checkOutput("bp_hold_fflags", {27'b0, fflags}, {27'b0, expA[4:0]});
            @(negedge clk);
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp_drain_a", result, expA[36:5]);
        checkOutput("bp_ready_release", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
        #1;
        checkOutput("bp_drain_b_valid", {31'b0, outValid}, 32'd1);
        checkOutput("bp_drain_b", result, expB[36:5]);
        @(negedge clk);
        #1;
        checkOutput("bp_drain_c_valid", {31'b0, outValid}, 32'd1);
        checkOutput("bp_drain_c", result, expC[36:5]);
        checkOutput("bp_drain_c_fflags", {27'b0, fflags}, {27'b0, expC[4:0]});
        @(negedge clk);
        #1;
        checkOutput("bp_empty", {31'b0, outValid}, 32'd0);

        // Reset with two items in flight must drop both.
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b1;
        urnd = mkRec(vecs[1]);
        rm = vecs[1].rm;
        @(negedge clk);
        urnd = mkRec(vecs[4]);
        rm = vecs[4].rm;
        @(negedge clk);
        #1;
        checkOutput("flight_valid_before_reset", {31'b0, outValid}, 32'd1);
        inValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b1;
        #1;
        checkOutput("midreset_out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("midreset_in_ready", {31'b0, inReady}, 32'd1);
`ifdef FP_RND_INEXACT_CNT_EN
        checkOutput("midreset_nx_cnt", {16'b0, nxCnt}, 32'd0);
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checkOutput("midreset_no_stale", {31'b0, outValid}, 32'd0);
        end

        // Random traffic against the scoreboard.
        pending = 1'b0;
        nxModel = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                rv = randVec();
                urnd = mkRec(rv);
                rm = rv.rm;
                inValid = ($urandom_range(0, 3) != 0);
                pending = inValid;
            end
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            if (inValid && inReady) begin
                expV = refModel(urnd, rm);
                qRes.push_back(expV[36:5]);
                qFl.push_back(expV[4:0]);
                pending = 1'b0;
            end
            if (outValid && outReady) begin
                if (qRes.size() == 0) begin
                    checkOutput("rand_unexpected_output", {31'b0, outValid}, 32'd0);
                end else begin
                    if (qFl[0][0]) nxModel++;
                    checkOutput("rand_result", result, qRes.pop_front());
                    checkOutput("rand_fflags", {27'b0, fflags}, {27'b0, qFl.pop_front()});
                end
            end
        end
        @(negedge clk);
        inValid = 1'b0;
        outReady = 1'b1;
        guard = 0;
        while (qRes.size() != 0 && guard < 20) begin
            #1;
            if (outValid) begin
                if (qFl[0][0]) nxModel++;
                checkOutput("drain_result", result, qRes.pop_front());
                checkOutput("drain_fflags", {27'b0, fflags}, {27'b0, qFl.pop_front()});
            end
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_complete", qRes.size(), 0);
`ifdef FP_RND_INEXACT_CNT_EN
        #1;
        checkOutput("nx_cnt_total", {16'b0, nxCnt}, nxModel);
        nxCntClr = 1'b1;
        @(negedge clk);
        nxCntClr = 1'b0;
        #1;
        checkOutput("nx_cnt_clear", {16'b0, nxCnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
